// File: rtl/img_mem_arbiter.sv
// Shares one single-port image RAM between a VGA pixel fetcher and a CPU/loader.
// VGA wins contention unless the CPU has waited STARVE_MAX cycles.
module img_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  output logic [15:0]       vga_miss_cnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ISSUE,
    CPU_WAIT
  } state_t;

  state_t          state;
  logic [SW-1:0]   starve;
  logic            tag_vga;
  logic            tag_cpu;
  logic            tag_cpu_rd;
  logic            at_max;
  logic            cpu_gnt;
  logic            vga_gnt;

  assign at_max  = (starve == SW'(STARVE_MAX));
  assign cpu_gnt = (state == IDLE) && cpu_req && (!vga_req || at_max);
  assign vga_gnt = vga_req && !cpu_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve       <= '0;
      tag_vga      <= 1'b0;
      tag_cpu      <= 1'b0;
      tag_cpu_rd   <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      vga_valid    <= 1'b0;
      vga_rdata    <= '0;
      vga_miss     <= 1'b0;
      vga_miss_cnt <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE:      if (cpu_gnt) state <= CPU_ISSUE;
        CPU_ISSUE: state <= CPU_WAIT;
        CPU_WAIT:  state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (cpu_gnt || !cpu_req)
        starve <= '0;
      else if (state == IDLE && !at_max)
        starve <= starve + 1'b1;

      mem_we <= 1'b0;
      if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end else if (vga_gnt) begin
        mem_addr  <= vga_addr;
      end

      // RAM data for the previous edge's grant arrives one cycle later
      tag_vga    <= vga_gnt;
      tag_cpu    <= cpu_gnt;
      tag_cpu_rd <= cpu_gnt && !cpu_we;

      vga_valid <= tag_vga;
      if (tag_vga) vga_rdata <= mem_q;
      cpu_ack <= tag_cpu;
      if (tag_cpu_rd) cpu_rdata <= mem_q;

      vga_miss <= cpu_gnt && vga_req;
      if (cpu_gnt && vga_req && vga_miss_cnt != 16'hFFFF)
        vga_miss_cnt <= vga_miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Scoreboard bench for img_mem_arbiter with a combinational-read RAM model.
// Stimulus pushes expected read data; a negedge monitor pops on each valid/ack.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [17:0] vga_addr;
  logic        vga_valid;
  logic [7:0]  vga_rdata;
  logic        vga_miss;
  logic [15:0] vga_miss_cnt;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_q;

  logic [7:0]  ram [0:255];
  logic [7:0]  vga_q [$];
  logic [8:0]  cpu_q [$];
  int checks = 0;
  int errors = 0;
  int miss_pulses = 0;

  always #5 clk = ~clk;

  img_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_valid(vga_valid), .vga_rdata(vga_rdata),
    .vga_miss(vga_miss), .vga_miss_cnt(vga_miss_cnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  assign mem_q = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[8'h10] <= 8'h5A;
      ram[8'h30] <= 8'hC3;
      ram[8'h40] <= 8'h77;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (vga_valid) begin
        if (vga_q.size() == 0) check("vga_valid_unexpected", 1, 0);
        else check("vga_rdata", {24'd0, vga_rdata}, {24'd0, vga_q.pop_front()});
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) check("cpu_ack_unexpected", 1, 0);
        else begin
          logic [8:0] e;
          e = cpu_q.pop_front();
          if (e[8]) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e[7:0]});
          else check("cpu_ack_write", {31'd0, cpu_ack}, 1);
        end
      end
      if (vga_miss) miss_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic cpu_txn(input logic we, input logic [17:0] a,
                         input logic [7:0] d, input int max_cyc,
                         output int cyc);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!cpu_ack && cyc < max_cyc);
    if (!cpu_ack) check("cpu_ack_timeout", 0, 1);
    cpu_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      vga_req = 1'($urandom); vga_addr = 18'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 18'($urandom); cpu_wdata = 8'($urandom);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();
    check("rst_mem_addr", {14'd0, mem_addr}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_vga_valid", {31'd0, vga_valid}, 0);
    check("rst_vga_rdata", {24'd0, vga_rdata}, 0);
    check("rst_vga_miss", {31'd0, vga_miss}, 0);
    check("rst_vga_miss_cnt", {16'd0, vga_miss_cnt}, 0);
    check("rst_cpu_ack", {31'd0, cpu_ack}, 0);
    check("rst_cpu_rdata", {24'd0, cpu_rdata}, 0);

    // VGA read at 0x10
    vga_req = 1; vga_addr = 18'h10;
    vga_q.push_back(8'h5A);
    tick();
    vga_req = 0;
    check("vga_mem_addr", {14'd0, mem_addr}, 32'h10);
    check("vga_mem_we", {31'd0, mem_we}, 0);
    check("vga_valid_early", {31'd0, vga_valid}, 0);
    tick();
    check("vga_valid_lat2", {31'd0, vga_valid}, 1);
    tick();
    check("vga_valid_pulse", {31'd0, vga_valid}, 0);
    check("vga_rdata_hold", {24'd0, vga_rdata}, 32'h5A);

    // CPU write, VGA idle
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h20; cpu_wdata = 8'hAB;
    cpu_q.push_back({1'b0, 8'h00});
    tick();
    check("wr_mem_we", {31'd0, mem_we}, 1);
    check("wr_mem_addr", {14'd0, mem_addr}, 32'h20);
    check("wr_mem_wdata", {24'd0, mem_wdata}, 32'hAB);
    check("wr_ack_early", {31'd0, cpu_ack}, 0);
    tick();
    check("wr_mem_we_off", {31'd0, mem_we}, 0);
    check("wr_ack", {31'd0, cpu_ack}, 1);
    cpu_req = 0;
    tick();
    check("wr_ack_pulse", {31'd0, cpu_ack}, 0);
    tick();
    check("wr_ram", {24'd0, ram[8'h20]}, 32'hAB);

    // CPU read back of written data
    cpu_q.push_back({1'b1, 8'hAB});
    cpu_txn(1'b0, 18'h20, 8'h00, 10, cyc);
    check("rd_latency", cyc, 2);
    tick(); tick();

    // Contention: VGA always requesting, CPU read must be forced through
    vga_req = 1; vga_addr = 18'h10;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h30;
    cpu_q.push_back({1'b1, 8'hC3});
    for (int i = 0; i < 19; i++) vga_q.push_back(8'h5A);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) check("cont_first_vga", {14'd0, mem_addr}, 32'h10);
      if (i == 16) check("cont_no_early_miss", {31'd0, vga_miss}, 0);
      if (i == 17) begin
        check("cont_cpu_grant", {14'd0, mem_addr}, 32'h30);
        check("cont_vga_miss", {31'd0, vga_miss}, 1);
        check("cont_miss_cnt", {16'd0, vga_miss_cnt}, 1);
      end
      if (i == 18) begin
        check("cont_cpu_ack", {31'd0, cpu_ack}, 1);
        check("cont_miss_pulse", {31'd0, vga_miss}, 0);
        cpu_req = 0;
      end
    end
    vga_req = 0;
    tick(); tick(); tick();
    check("cont_miss_pulses", miss_pulses, 1);
    check("cont_miss_cnt_hold", {16'd0, vga_miss_cnt}, 1);

    // Reset with a CPU read in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h40;
    tick();
    check("rst_flight_grant", {14'd0, mem_addr}, 32'h40);
    rst = 1;
    cpu_req = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst_flight_no_ack", {31'd0, cpu_ack}, 0);
      tick();
    end
    check("rst_flight_miss_cnt", {16'd0, vga_miss_cnt}, 0);
    cpu_q.push_back({1'b1, 8'h77});
    cpu_txn(1'b0, 18'h40, 8'h00, 10, cyc);
    check("post_rst_latency", cyc, 2);
    tick(); tick(); tick();

    check("vga_q_drained", vga_q.size(), 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
